fadd_mant_stage: RTL and testbench
==================================

# fadd_mant_stage

Parametrised mantissa add/subtract stage of the floating-point adder pipeline. Sits after exponent alignment and before normalisation. Takes two aligned mantissas with signs, a shared exponent and an add/sub mode, and produces a sign-magnitude sum with carry and zero flags. Provides valid/ready handshaking and a 2-entry output buffer so backpressure from normalisation never drops or duplicates an operation.

## Interface
Parameters:
- MANT_W, 24, mantissa width including hidden bit
- EXP_W, 8, exponent width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffered results
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept an operation this cycle
- mant_a  in  MANT_W  aligned mantissa of the larger-exponent operand
- mant_b  in  MANT_W  aligned (right-shifted) mantissa of the other operand
- sign_a  in  1  sign of operand a
- sign_b  in  1  sign of operand b
- exp_in  in  EXP_W  common exponent (that of a)
- sub_op  in  1  1 = compute a - b, 0 = a + b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum_mag  out  MANT_W+1  result magnitude; MSB is carry
- sign_out  out  1  result sign
- exp_out  out  EXP_W  exp_in passed through
- carry_out  out  1  equals sum_mag[MANT_W]
- zero_out  out  1  sum_mag == 0

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- eff_sub = sign_a ^ sign_b ^ sub_op.
- eff_sub = 0: sum_mag = mant_a + mant_b, zero-extended to MANT_W+1 bits; sign_out = sign_a.
- eff_sub = 1, mant_a >= mant_b: sum_mag = mant_a - mant_b; sign_out = sign_a.
- eff_sub = 1, mant_a < mant_b: sum_mag = mant_b - mant_a; sign_out = ~sign_a. The magnitude is never negative and never wraps.
- eff_sub = 1 with sum_mag == 0: sign_out = 0 (+0).
- eff_sub = 0 with both mantissas zero: sign_out = sign_a.
- Results are computed combinationally at the input and written into a 2-entry FIFO. The FIFO is pointer-based with wr_ptr/rd_ptr wrapping modulo 2 and count in 0..2.
- in_ready = (count != 2), driven from registered state only with no combinational path from out_ready. A pop in the same cycle does not open a full buffer.
- out_valid = (count != 0). Output fields come from the rd_ptr entry.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- flush = 1: count, wr_ptr and rd_ptr go to 0, and any same-cycle input transfer is discarded. flush has priority over push and pop.
- Results leave in acceptance order.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, out_valid = 0, in_ready = 1, and all data outputs = 0. No transfer occurs while rst_n is low.
- Latency: an operation accepted at edge N is on the outputs with out_valid = 1 after edge N, provided the buffer was empty.
- Throughput: 1 operation per cycle while out_ready = 1.
- Output hold: while out_valid = 1 and out_ready = 0, all output fields stay stable.
- Stall: with out_ready held low, exactly 2 operations are accepted, then in_ready = 0 until the first pop edge. in_ready returns to 1 the cycle after that edge.
- Reset asserted mid-stream: buffered results are lost and outputs immediately take their reset values.

## Test plan
- Add with carry (MANT_W = 24): a = 0x800000, b = 0x800000, signs 0, sub_op = 0 -> sum_mag = 0x1000000, carry_out = 1, sign_out = 0, exp_out = exp_in, out_valid one edge after acceptance.
- Effective subtract, a larger: a = 0xC00000, b = 0x400000, sign_a = 0, sign_b = 1, sub_op = 0 -> sum_mag = 0x0800000, sign_out = 0. Same values with sign_b = 0, sub_op = 1 -> identical result.
- Swap case: a = 0x400000, b = 0xC00000, sign_a = 0, eff_sub = 1 -> sum_mag = 0x0800000, sign_out = 1. Exact cancellation a = b = 0xABCDEF, eff_sub = 1, sign_a = 1 -> sum_mag = 0, zero_out = 1, sign_out = 0.
- Backpressure: in_valid held 1 with incrementing mant_a 1, 2, 3, 4 and out_ready low for 4 cycles -> only ops 1 and 2 accepted, in_ready = 0 from the following cycle, outputs stable. Then raise out_ready -> ops 1, 2, 3, 4 emerge in order with no loss or duplication.
- Streaming: 20 back-to-back random ops with out_ready = 1 -> one result per cycle, each matching the reference model.
- Flush and reset: buffer full, assert flush with in_valid = 1 for 1 cycle -> out_valid = 0, in_ready = 1 next cycle, and the flushed input never appears at the output. Drop rst_n asynchronously between edges -> out_valid falls immediately, all outputs 0.

Source files
------------

// File: rtl/fadd_mant_stage.sv
// fadd_mant_stage
//   Mantissa add/subtract stage of the floating-point adder. Sits between
//   exponent alignment and normalisation. Each accepted operation produces a
//   sign-magnitude sum. The result is computed combinationally at the input
//   and parked in a 2-entry FIFO, so backpressure from normalisation never
//   drops or duplicates an operation.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. Valid must not depend on ready. in_ready is a pure function of
//   registered state, so there is no out_ready -> in_ready path.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   flush            synchronous clear of buffered results (beats push/pop)
//   in_valid/ready   input handshake
//   mant_a, mant_b   aligned mantissas (a = larger-exponent operand)
//   sign_a, sign_b   operand signs
//   exp_in           shared exponent, passed through to exp_out
//   sub_op           1 = a - b, 0 = a + b
//   out_valid/ready  output handshake
//   sum_mag          result magnitude, MSB is the carry
//   sign_out         result sign
//   exp_out          exponent of the result
//   carry_out        sum_mag[MANT_W]
//   zero_out         sum_mag == 0
module fadd_mant_stage #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sub_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W:0]   sum_mag,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              carry_out,
  output logic              zero_out
);

  // Each entry holds {magnitude, sign, exponent}.
  localparam int ENT_W = (MANT_W + 1) + 1 + EXP_W;

  logic [ENT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             eff_sub;
  logic [MANT_W:0]  ext_a;
  logic [MANT_W:0]  ext_b;
  logic [MANT_W:0]  res_mag;
  logic             res_sign;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // Combinational add/sub. On an effective subtract the smaller mantissa is
  // always subtracted from the larger, so the magnitude never wraps; the
  // sign flips when b was the larger one, and exact cancellation gives +0.
  always_comb begin
    ext_a    = {1'b0, mant_a};
    ext_b    = {1'b0, mant_b};
    eff_sub  = sign_a ^ sign_b ^ sub_op;
    res_mag  = '0;
    res_sign = sign_a;
    if (!eff_sub) begin
      res_mag = ext_a + ext_b;
    end else if (mant_a >= mant_b) begin
      res_mag = ext_a - ext_b;
      if (res_mag == '0) res_sign = 1'b0;
    end else begin
      res_mag  = ext_b - ext_a;
      res_sign = ~sign_a;
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Occupancy and pointers. flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {res_mag, res_sign, exp_in};
  end

  // Data outputs are forced to zero whenever no result is held, which also
  // makes them read zero immediately when reset is asserted.
  assign head = out_valid ? mem[rd_ptr] : '0;
  assign sum_mag   = head[ENT_W-1 -: (MANT_W + 1)];
  assign sign_out  = head[EXP_W];
  assign exp_out   = head[EXP_W-1:0];
  assign carry_out = sum_mag[MANT_W];
  assign zero_out  = out_valid & (sum_mag == '0);

endmodule

// File: tb/tb_fadd_mant_stage.sv
// Testbench for fadd_mant_stage (MANT_W = 24, EXP_W = 8).
// Driver issues operations at the falling edge and pushes the expected
// result into exp_q when the handshake will complete at the next rising
// edge; an independent monitor pops and compares every output transfer.
module tb_fadd_mant_stage;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int QW = (MW + 1) + 1 + EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mant_a = '0;
  logic [MW-1:0] mant_b = '0;
  logic          sign_a = 1'b0;
  logic          sign_b = 1'b0;
  logic [EW-1:0] exp_in = '0;
  logic          sub_op = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW:0]   sum_mag;
  logic          sign_out;
  logic [EW-1:0] exp_out;
  logic          carry_out;
  logic          zero_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [QW-1:0] exp_q[$];

  fadd_mant_stage #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_a(mant_a), .mant_b(mant_b), .sign_a(sign_a), .sign_b(sign_b),
    .exp_in(exp_in), .sub_op(sub_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_mag(sum_mag), .sign_out(sign_out), .exp_out(exp_out),
    .carry_out(carry_out), .zero_out(zero_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: signed integer arithmetic on the operands.
  function automatic logic [QW-1:0] model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                          input logic sa, input logic sb, input logic sub,
                                          input logic [EW-1:0] e);
    longint va, vb, r;
    logic [MW:0] m;
    logic s;
    va = sa ? -longint'(a) : longint'(a);
    vb = (sb ^ sub) ? -longint'(b) : longint'(b);
    r  = va + vb;
    if (r < 0) begin
      m = (MW+1)'(-r); s = 1'b1;
    end else if (r > 0) begin
      m = (MW+1)'(r);  s = 1'b0;
    end else begin
      m = '0; s = (sa ^ sb ^ sub) ? 1'b0 : sa;
    end
    return {m, s, e};
  endfunction

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b,
                       input logic sa, input logic sb, input logic sub,
                       input logic [EW-1:0] e, input logic [QW-1:0] expv);
    int n;
    mant_a = a; mant_b = b; sign_a = sa; sign_b = sb; sub_op = sub; exp_in = e;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    end else begin
      exp_q.push_back(expv);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [QW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got sum_mag=%0h, expected no result", sum_mag);
        end else begin
          e = exp_q.pop_front();
          check("sum_mag",   sum_mag,   e[QW-1 -: MW+1]);
          check("sign_out",  sign_out,  e[EW]);
          check("exp_out",   exp_out,   e[EW-1:0]);
          check("carry_out", carry_out, e[QW-1]);
          check("zero_out",  zero_out,  (e[QW-1 -: MW+1] == '0));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nxt, n, c0;
    logic [MW-1:0] ra, rb;
    logic rsa, rsb, rsub;
    logic [EW-1:0] re;

    // Reset state
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready",  in_ready,  1'b1);
    check("reset_sum_mag",   sum_mag,   '0);
    check("reset_zero_out",  zero_out,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add with carry; result visible right after the accepting edge
    issue(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 8'h85, {25'h1000000, 1'b0, 8'h85});
    check("latency_out_valid", out_valid, 1'b1);
    check("latency_in_ready",  in_ready,  1'b1);
    check("latency_carry",     carry_out, 1'b1);
    drain();

    // Effective subtracts, swap, cancellation, zero add, max add
    out_ready = 1'b1;
    issue(24'hC00000, 24'h400000, 1'b0, 1'b1, 1'b0, 8'h10, {25'h0800000, 1'b0, 8'h10});
    issue(24'hC00000, 24'h400000, 1'b0, 1'b0, 1'b1, 8'h11, {25'h0800000, 1'b0, 8'h11});
    issue(24'h400000, 24'hC00000, 1'b0, 1'b1, 1'b0, 8'h12, {25'h0800000, 1'b1, 8'h12});
    issue(24'hABCDEF, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 8'h13, {25'h0000000, 1'b0, 8'h13});
    issue(24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0, 8'h14, {25'h0000000, 1'b1, 8'h14});
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 8'h15, {25'h1FFFFFE, 1'b1, 8'h15});
    issue(24'h000001, 24'h000002, 1'b1, 1'b1, 1'b1, 8'h16, {25'h0000001, 1'b0, 8'h16});
    drain();

    // Backpressure: only two accepted while out_ready is low
    out_ready = 1'b0;
    nxt = 1;
    for (int c = 0; c < 4; c++) begin
      mant_a = MW'(nxt); mant_b = '0; sign_a = 1'b0; sign_b = 1'b0; sub_op = 1'b0;
      exp_in = 8'h40; in_valid = 1'b1;
      if (c >= 2) check("stall_in_ready", in_ready, 1'b0);
      if (c >= 1) check("stall_hold_sum", sum_mag, 25'd1);
      if (in_ready) begin
        exp_q.push_back({25'(nxt), 1'b0, 8'h40});
        nxt++;
      end
      @(negedge clk);
    end
    check("stall_accepted", nxt - 1, 2);
    out_ready = 1'b1;
    n = 0;
    while (nxt <= 4 && n < 20) begin
      mant_a = MW'(nxt); in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back({25'(nxt), 1'b0, 8'h40});
        nxt++;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    drain();

    // Streaming: one result per cycle against the reference model
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      ra = MW'($urandom_range(0, 32'hFFFFFF));
      rb = MW'($urandom_range(0, 32'hFFFFFF));
      if (i % 5 == 0) rb = ra;
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      re = EW'($urandom_range(0, 255));
      issue(ra, rb, rsa, rsb, rsub, re, model(ra, rb, rsa, rsb, rsub, re));
    end
    check("stream_cycles", cyc - c0, 20);
    drain();

    // Flush with a full buffer and a pending input
    out_ready = 1'b0;
    issue(24'h000100, 24'h000001, 1'b0, 1'b0, 1'b0, 8'h20, {25'h0000101, 1'b0, 8'h20});
    issue(24'h000200, 24'h000001, 1'b0, 1'b0, 1'b0, 8'h21, {25'h0000201, 1'b0, 8'h21});
    check("full_in_ready", in_ready, 1'b0);
    mant_a = 24'h123456; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready",  in_ready,  1'b1);

    // Flush with room: the same-cycle input must still be discarded
    issue(24'h000300, 24'h000001, 1'b0, 1'b0, 1'b0, 8'h22, {25'h0000301, 1'b0, 8'h22});
    mant_a = 24'h654321; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush2_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_flush_idle", out_valid, 1'b0);

    // Asynchronous reset between edges with a full buffer
    out_ready = 1'b0;
    issue(24'h00000F, 24'h000001, 1'b0, 1'b0, 1'b0, 8'h30, {25'h0000010, 1'b0, 8'h30});
    issue(24'h00001F, 24'h000001, 1'b0, 1'b0, 1'b0, 8'h31, {25'h0000020, 1'b0, 8'h31});
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready",  in_ready,  1'b1);
    check("arst_sum_mag",   sum_mag,   '0);
    check("arst_sign_exp",  {sign_out, exp_out}, '0);
    check("arst_flags",     {carry_out, zero_out}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    issue(24'h000005, 24'h000007, 1'b0, 1'b0, 1'b1, 8'h32, {25'h0000002, 1'b1, 8'h32});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
